// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: synchronise, debounce, decode and sequence-check an async counter bus.
// Define JOHNSON_DECODE_EN for twisted-ring input codes; otherwise codes are plain binary.
module ripple_count_sampler #(
    parameter int WIDTH      = 3,
    parameter int STABLE_CYC = 2,
    parameter int ERR_W      = 8,
    parameter int WRAP_W     = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WIDTH-1:0]  cnt_in,
    output logic [WIDTH-1:0]  cnt_out,
    output logic [WIDTH-1:0]  idx_out,
    output logic              upd,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              locked
);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);
`ifdef JOHNSON_DECODE_EN
    localparam int N = 2 * WIDTH;
`else
    localparam int N = 2 ** WIDTH;
`endif
    localparam logic [WIDTH-1:0] IDX_MAX = WIDTH'(N - 1);

    typedef enum logic {S_INIT, S_TRACK} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  s1, s2;
    logic              v1, v2, taken, taken_nxt;
    logic [SW-1:0]     stab, stab_nxt;
    logic              reload, accept, code_ok, legal;
    logic [WIDTH-1:0]  code_idx, idx_succ;
    logic [WIDTH-1:0]  cnt_nxt, idx_nxt;
    logic              upd_nxt, err_nxt, wrap_nxt, locked_nxt;
    logic [ERR_W-1:0]  err_cnt_nxt;
    logic [WRAP_W-1:0] wrap_cnt_nxt;

`ifdef JOHNSON_DECODE_EN
    logic [WIDTH-1:0] inv, ones;
    // Legal codes are a bit0-anchored run of ones, or the complement of one.
    always_comb begin
        inv  = ~s2;
        ones = '0;
        for (int i = 0; i < WIDTH; i++) ones = ones + WIDTH'(s2[i]);
        code_ok  = ((s2 & (s2 + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0);
        code_idx = (s2[0] || s2 == '0) ? ones : WIDTH'(2 * WIDTH) - ones;
    end
`else
    assign code_ok  = 1'b1;
    assign code_idx = s2;
`endif

    // v1/v2 mark the sync stages as holding post-reset samples, so the
    // first value after reset sees the same latency as any later change.
    assign reload    = !v1 || !v2 || s1 != s2;
    assign stab_nxt  = !v1 ? '0 : reload ? SW'(1) : (stab == STAB_MAX) ? stab : stab + SW'(1);
    assign accept    = stab == STAB_MAX && !taken && (state == S_INIT || s2 != cnt_out);
    assign taken_nxt = !reload && (taken || accept);
    assign idx_succ  = (idx_out == IDX_MAX) ? '0 : idx_out + WIDTH'(1);
    assign legal     = code_idx == idx_succ;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt_out;
        idx_nxt      = idx_out;
        upd_nxt      = 1'b0;
        err_nxt      = 1'b0;
        wrap_nxt     = 1'b0;
        locked_nxt   = locked;
        err_cnt_nxt  = err_cnt;
        wrap_cnt_nxt = wrap_cnt;
        if (accept) begin
            if (!code_ok) begin
                err_nxt = 1'b1;
            end else begin
                cnt_nxt    = s2;
                idx_nxt    = code_idx;
                upd_nxt    = 1'b1;
                locked_nxt = 1'b1;
                state_nxt  = S_TRACK;
                err_nxt    = state == S_TRACK && !legal;
                wrap_nxt   = state == S_TRACK && legal && idx_out == IDX_MAX;
            end
            err_cnt_nxt  = (err_nxt && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
            wrap_cnt_nxt = wrap_nxt ? wrap_cnt + WRAP_W'(1) : wrap_cnt;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1       <= '0;
            s2       <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            stab     <= '0;
            taken    <= 1'b0;
            state    <= S_INIT;
            cnt_out  <= '0;
            idx_out  <= '0;
            upd      <= 1'b0;
            err      <= 1'b0;
            wrap     <= 1'b0;
            locked   <= 1'b0;
            err_cnt  <= '0;
            wrap_cnt <= '0;
        end else begin
            s1       <= cnt_in;
            s2       <= s1;
            v1       <= 1'b1;
            v2       <= v1;
            stab     <= stab_nxt;
            taken    <= taken_nxt;
            state    <= state_nxt;
            cnt_out  <= cnt_nxt;
            idx_out  <= idx_nxt;
            upd      <= upd_nxt;
            err      <= err_nxt;
            wrap     <= wrap_nxt;
            locked   <= locked_nxt;
            err_cnt  <= err_cnt_nxt;
            wrap_cnt <= wrap_cnt_nxt;
        end
    end
endmodule
